ucomb_cfg_loader: RTL

UCOMB_CFG_LOADER -- requirements
Module: ucomb_cfg_loader

---
 rtl/ucomb_pkg.sv | 18 +
 rtl/ucomb_cfg_loader.sv | 87 ++++++++
 2 files changed

// File: rtl/ucomb_pkg.sv
// Shared opcodes and FSM state type for the unigate configuration loader.
package ucomb_pkg;

    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_SEL  = 2'd1;
    localparam logic [1:0] OP_FUNC = 2'd2;
    localparam logic [1:0] OP_PIN  = 2'd3;

    typedef enum logic [2:0] {
        IDLE, WR_SEL, WR_FUNC, WR_PIN, SETTLE, RESP
    } state_t;

    // Command word as seen on the bus: 17-bit payload above a 2-bit opcode.
    function automatic logic [18:0] mk_cmd(input logic [1:0] op, input logic [16:0] data);
        return {data, op};
    endfunction

endpackage

// File: rtl/ucomb_cfg_loader.sv
// Writes sel/func/pin into the unigate wrapper, waits for it to settle,
// then hands the wrapper's readback to the consumer.
module ucomb_cfg_loader
    import ucomb_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_sel,
    input  logic [15:0] cfg_func,
    input  logic [3:0]  cfg_pin,
    input  logic [16:0] test_vec,
    output logic [18:0] bus_out,
    input  logic [5:0]  wpin_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [5:0]  rsp_wpin
);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [1:0]  sel_q;
    logic [15:0] func_q;
    logic [3:0]  pin_q;
    logic        accept;
    logic        settle_done;

    assign accept      = cfg_valid && cfg_ready;
    assign settle_done = (state == SETTLE) && (cnt == 4'(SETTLE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) state_nxt = WR_SEL;
            end
            WR_SEL:  state_nxt = WR_FUNC;
            WR_FUNC: state_nxt = WR_PIN;
            WR_PIN:  state_nxt = SETTLE;
            SETTLE:  if (settle_done) state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The bus is registered: each state loads the command for the state that follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_out  <= '0;
            rsp_wpin <= '0;
            cnt      <= '0;
            sel_q    <= '0;
            func_q   <= '0;
            pin_q    <= '0;
        end else begin
            cnt <= (state == SETTLE && !settle_done) ? cnt + 4'd1 : 4'd0;
            if (accept) begin
                sel_q  <= cfg_sel;
                func_q <= cfg_func;
                pin_q  <= cfg_pin;
            end
            if (settle_done) rsp_wpin <= wpin_in;
            case (state)
                IDLE:    bus_out <= accept ? mk_cmd(OP_SEL, {15'b0, cfg_sel})
                                           : mk_cmd(OP_NOP, test_vec);
                WR_SEL:  bus_out <= mk_cmd(OP_FUNC, {1'b0, func_q});
                WR_FUNC: bus_out <= mk_cmd(OP_PIN, {13'b0, pin_q});
                default: bus_out <= '0;
            endcase
        end
    end

endmodule
